// File: rtl/cpu_pkg.sv
// Shared opcode/subcode encodings and decode helpers for the ALU, decode and writeback stages.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_MEM   = 4'h7;
  localparam logic [3:0] OP_BZ    = 4'hC;
  localparam logic [3:0] OP_BNZ   = 4'hD;
  localparam logic [3:0] OP_LDI   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] SUB_LD = 4'h0;
  localparam logic [3:0] SUB_ST = 4'h1;

  function automatic logic is_reg_writer(input logic [3:0] opcode, input logic [3:0] subcode);
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_LDI: return 1'b1;
      OP_MEM:                                                  return subcode == SUB_LD;
      default:                                                 return 1'b0;
    endcase
  endfunction

  // The unused 1000-1011 opcode block is treated as a halt so stray code stops cleanly.
  function automatic logic is_halt_op(input logic [3:0] opcode);
    return (opcode == OP_HALT) || (opcode[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/print_fifo.sv
// Pointer-based console byte FIFO; the head byte reads as zero whenever the FIFO is empty.
module print_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
    dout = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

  // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; stale bytes are unreachable because dout is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: WB register, bypassed 16x16 register file, jump redirect,
// console print FIFO on writes to r0, and sticky halt.
module writeback
  import cpu_pkg::*;
#(
  parameter int PRINT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x2_valid,
  input  logic [15:0] x2_pc,
  input  logic [15:0] x2_ins,
  input  logic [15:0] x2_result,
  input  logic [3:0]  rd_addr_a,
  input  logic [3:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic        wb_stall,
  output logic        wb_redirect,
  output logic [15:0] wb_redirect_pc,
  output logic        print_valid,
  output logic [7:0]  print_data,
  input  logic        print_ready,
  output logic        halted,
  output logic [31:0] retired
);

  logic        wb_valid_q, wb_valid_d;
  logic [15:0] wb_pc_q, wb_pc_d;
  logic [15:0] wb_ins_q, wb_ins_d;
  logic [15:0] wb_result_q, wb_result_d;
  logic [15:0] regs_q [1:15];
  logic [15:0] regs_d [1:15];
  logic        halted_q, halted_d;
  logic [31:0] retired_q, retired_d;

  logic [3:0]  opcode, subcode, wb_rt;
  logic        writes_reg, is_print, is_jump, is_halt;
  logic        active, reg_we;
  logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic        unused_rs_bits;

  assign unused_rs_bits = ^wb_ins_q[11:8];

  always_comb begin
    opcode     = wb_ins_q[15:12];
    subcode    = wb_ins_q[7:4];
    wb_rt      = wb_ins_q[3:0];
    writes_reg = is_reg_writer(opcode, subcode);
    is_print   = writes_reg && (wb_rt == 4'd0);
    is_jump    = (opcode == OP_JMP);
    is_halt    = is_halt_op(opcode);

    // Stall looks only at fullness; a same-cycle pop frees the slot for the next cycle.
    wb_stall   = wb_valid_q && !halted_q && is_print && fifo_full;
    active     = wb_valid_q && !halted_q && !wb_stall;
    reg_we     = active && writes_reg && (wb_rt != 4'd0);
    fifo_push  = active && is_print;

    wb_redirect    = active && is_jump && (wb_result_q != wb_pc_q + 16'd2);
    wb_redirect_pc = wb_redirect ? wb_result_q : 16'h0000;

    print_valid = !fifo_empty;
    fifo_pop    = print_valid && print_ready;

    wb_valid_d  = wb_valid_q;
    wb_pc_d     = wb_pc_q;
    wb_ins_d    = wb_ins_q;
    wb_result_d = wb_result_q;
    if (!wb_stall) begin
      wb_valid_d  = x2_valid;
      wb_pc_d     = x2_pc;
      wb_ins_d    = x2_ins;
      wb_result_d = x2_result;
    end

    regs_d = regs_q;
    if (reg_we) regs_d[wb_rt] = wb_result_q;

    halted_d  = halted_q || (active && is_halt);
    retired_d = retired_q + 32'(active);
  end

  // Bypass only when the WB instruction is actually committing a register write.
  always_comb begin
    rd_data_a = 16'h0000;
    rd_data_b = 16'h0000;
    if (rd_addr_a != 4'd0)
      rd_data_a = (reg_we && rd_addr_a == wb_rt) ? wb_result_q : regs_q[rd_addr_a];
    if (rd_addr_b != 4'd0)
      rd_data_b = (reg_we && rd_addr_b == wb_rt) ? wb_result_q : regs_q[rd_addr_b];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_ins_q    <= '0;
      wb_result_q <= '0;
      for (int i = 1; i < 16; i++) regs_q[i] <= '0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_ins_q    <= wb_ins_d;
      wb_result_q <= wb_result_d;
      regs_q      <= regs_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign halted  = halted_q;
  assign retired = retired_q;

  print_fifo #(.DEPTH(PRINT_DEPTH)) u_print_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (wb_result_q[7:0]),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (print_data),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: directed scenarios plus randomized traffic against a
// per-instruction reference model; printed bytes and redirects are checked by a monitor.
module tb_writeback;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        v;
    logic [15:0] pc;
    logic [15:0] ins;
    logic [15:0] res;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x2_valid = 1'b0;
  logic [15:0] x2_pc = '0, x2_ins = '0, x2_result = '0;
  logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        wb_stall, wb_redirect;
  logic [15:0] wb_redirect_pc;
  logic        print_valid;
  logic [7:0]  print_data;
  logic        print_ready = 1'b0;
  logic        halted;
  logic [31:0] retired;

  always #5 clk = ~clk;

  writeback #(.PRINT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .x2_valid(x2_valid), .x2_pc(x2_pc), .x2_ins(x2_ins), .x2_result(x2_result),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_stall(wb_stall), .wb_redirect(wb_redirect), .wb_redirect_pc(wb_redirect_pc),
    .print_valid(print_valid), .print_data(print_data), .print_ready(print_ready),
    .halted(halted), .retired(retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: one instruction in WB, architectural registers, FIFO occupancy.
  instr_t      m_wb;
  logic [15:0] m_regs [16];
  int          m_cnt;
  bit          m_halted;
  int unsigned m_retired;
  bit          m_stalled;
  instr_t      cur_x;
  logic [7:0]  exp_print [$];
  logic [15:0] exp_redir [$];

  function automatic instr_t mk(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                                input logic [15:0] res);
    instr_t t;
    t.v = v; t.pc = pc; t.ins = ins; t.res = res;
    return t;
  endfunction

  function automatic bit ref_writes(input logic [15:0] ins);
    case (ins[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hE: return 1'b1;
      4'h7:                                     return ins[7:4] == 4'h0;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic bit ref_halts(input logic [15:0] ins);
    return ins[15:12] == 4'hF || (ins[15:12] >= 4'h8 && ins[15:12] <= 4'hB);
  endfunction

  function automatic logic [15:0] ref_read(input logic [3:0] a, input bit byp,
                                           input logic [3:0] rt, input logic [15:0] res);
    if (a == 4'd0) return 16'h0000;
    if (byp && a == rt) return res;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    m_wb = mk(1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_cnt = 0; m_halted = 1'b0; m_retired = 0; m_stalled = 1'b0;
    exp_print.delete();
    exp_redir.delete();
  endtask

  // Compare this cycle's combinational outputs, queue expected events, advance the model by one edge.
  task automatic evaluate();
    logic [3:0] rt;
    bit wr, prn, stall, act, jmp_taken, pop, byp;
    rt        = m_wb.ins[3:0];
    wr        = m_wb.v && ref_writes(m_wb.ins);
    prn       = wr && rt == 4'd0;
    stall     = m_wb.v && !m_halted && prn && m_cnt == DEPTH;
    act       = m_wb.v && !m_halted && !stall;
    jmp_taken = act && m_wb.ins[15:12] == 4'h6 && m_wb.res != m_wb.pc + 16'd2;
    pop       = m_cnt > 0 && print_ready;
    byp       = act && wr && rt != 4'd0;

    check("wb_stall", wb_stall, stall);
    check("wb_redirect", wb_redirect, jmp_taken);
    check("print_valid", print_valid, m_cnt != 0);
    check("halted", halted, m_halted);
    check("retired", retired, m_retired);
    check("rd_data_a", rd_data_a, ref_read(rd_addr_a, byp, rt, m_wb.res));
    check("rd_data_b", rd_data_b, ref_read(rd_addr_b, byp, rt, m_wb.res));
    if (jmp_taken) exp_redir.push_back(m_wb.res);

    if (act) begin
      if (byp) m_regs[rt] = m_wb.res;
      if (prn) begin
        exp_print.push_back(m_wb.res[7:0]);
        m_cnt++;
      end
      if (ref_halts(m_wb.ins)) m_halted = 1'b1;
      m_retired++;
    end
    if (pop) m_cnt--;
    if (!stall) m_wb = cur_x;
    m_stalled = stall;
  endtask

  task automatic step(input instr_t x, input logic ready, input logic [3:0] aa, input logic [3:0] ab);
    @(posedge clk);
    #1;
    cur_x = x;
    x2_valid = x.v; x2_pc = x.pc; x2_ins = x.ins; x2_result = x.res;
    print_ready = ready; rd_addr_a = aa; rd_addr_b = ab;
    #2;
    evaluate();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3;
    rst = 1'b1;
    x2_valid = 1'b0;
    print_ready = 1'b0;
    model_reset();
    #1;
    check("rst_print_valid", print_valid, 1'b0);
    check("rst_print_data", print_data, 8'h00);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 32'd0);
    check("rst_wb_stall", wb_stall, 1'b0);
    check("rst_wb_redirect", wb_redirect, 1'b0);
    check("rst_redirect_pc", wb_redirect_pc, 16'h0000);
    check("rst_rd_data_a", rd_data_a, 16'h0000);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: consumes expected bytes/targets whenever the DUT presents a handshake or redirect.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (print_valid && print_ready) begin
          if (exp_print.size() == 0) check("print_unexpected", {24'h0, print_data}, 32'hFFFF_FFFF);
          else check("print_data", print_data, exp_print.pop_front());
        end
        if (wb_redirect) begin
          if (exp_redir.size() == 0) check("redirect_unexpected", wb_redirect_pc, 32'hFFFF_FFFF);
          else check("redirect_pc", wb_redirect_pc, exp_redir.pop_front());
        end
      end
    end
  end

  initial begin
    instr_t bub;
    instr_t rx;
    bub = mk(1'b0, 16'h0, 16'h0, 16'h0);
    model_reset();
    reset_dut();

    // Write + bypass
    step(mk(1'b1, 16'h0000, 16'h0123, 16'h00AA), 1'b1, 4'd3, 4'd0);
    step(bub, 1'b1, 4'd3, 4'd0);
    check("bypass_r3", rd_data_a, 16'h00AA);
    step(bub, 1'b1, 4'd3, 4'd0);
    check("regfile_r3", rd_data_a, 16'h00AA);
    check("retired_after_add", retired, 32'd1);

    // Jumps: taken redirect, then fall-through
    step(mk(1'b1, 16'h0010, 16'h6000, 16'h0040), 1'b1, 4'd0, 4'd0);
    step(bub, 1'b1, 4'd0, 4'd0);
    check("jump_redirect", wb_redirect, 1'b1);
    check("jump_target", wb_redirect_pc, 16'h0040);
    step(mk(1'b1, 16'h0010, 16'h6000, 16'h0012), 1'b1, 4'd0, 4'd0);
    check("redirect_one_cycle", wb_redirect, 1'b0);
    step(bub, 1'b1, 4'd0, 4'd0);
    check("jump_fallthrough", wb_redirect, 1'b0);
    step(bub, 1'b1, 4'd0, 4'd0);
    check("retired_after_jumps", retired, 32'd3);

    // r0 reads zero; store and 1100 write nothing
    step(mk(1'b1, 16'h0020, 16'h0000, 16'h0055), 1'b1, 4'd0, 4'd0);
    step(mk(1'b1, 16'h0022, 16'h7015, 16'hBEEF), 1'b1, 4'd0, 4'd0);
    check("r0_reads_zero", rd_data_a, 16'h0000);
    step(mk(1'b1, 16'h0024, 16'hC006, 16'hCAFE), 1'b1, 4'd5, 4'd6);
    step(bub, 1'b1, 4'd5, 4'd6);
    step(bub, 1'b1, 4'd5, 4'd6);
    check("store_no_write_r5", rd_data_a, 16'h0000);
    check("br_no_write_r6", rd_data_b, 16'h0000);
    check("retired_after_r0", retired, 32'd6);

    // Print FIFO fill and stall
    for (int i = 0; i < 5; i++)
      step(mk(1'b1, 16'h0030 + 16'(2*i), 16'h0000, 16'h0041 + 16'(i)), 1'b0, 4'd0, 4'd0);
    step(bub, 1'b0, 4'd0, 4'd0);
    check("fifo_full_stall", wb_stall, 1'b1);
    check("retired_at_stall", retired, 32'd10);
    step(bub, 1'b1, 4'd0, 4'd0);
    check("stall_ignores_ready", wb_stall, 1'b1);
    check("head_is_A", print_data, 8'h41);
    step(bub, 1'b0, 4'd0, 4'd0);
    check("stall_released", wb_stall, 1'b0);
    repeat (6) step(bub, 1'b1, 4'd0, 4'd0);
    check("retired_after_fifo", retired, 32'd11);

    // Halt: later instructions are ignored, FIFO still drains
    step(mk(1'b1, 16'h0040, 16'h0000, 16'h0078), 1'b0, 4'd5, 4'd0);
    step(mk(1'b1, 16'h0042, 16'h0000, 16'h0079), 1'b0, 4'd5, 4'd0);
    step(mk(1'b1, 16'h0044, 16'hF000, 16'h0000), 1'b0, 4'd5, 4'd0);
    step(mk(1'b1, 16'h0046, 16'h0005, 16'h5555), 1'b0, 4'd5, 4'd0);
    step(bub, 1'b0, 4'd5, 4'd0);
    check("halted_set", halted, 1'b1);
    step(bub, 1'b0, 4'd5, 4'd0);
    check("r5_unchanged", rd_data_a, 16'h0000);
    check("retired_frozen", retired, 32'd14);
    repeat (4) step(bub, 1'b1, 4'd5, 4'd0);
    check("drained_while_halted", print_valid, 1'b0);

    // Asynchronous reset with FIFO at 3 entries, r7 written and halted
    reset_dut();
    step(mk(1'b1, 16'h0100, 16'h0007, 16'h1234), 1'b0, 4'd7, 4'd0);
    step(mk(1'b1, 16'h0102, 16'h0000, 16'h0031), 1'b0, 4'd7, 4'd0);
    step(mk(1'b1, 16'h0104, 16'h0000, 16'h0032), 1'b0, 4'd7, 4'd0);
    step(mk(1'b1, 16'h0106, 16'h0000, 16'h0033), 1'b0, 4'd7, 4'd0);
    step(mk(1'b1, 16'h0108, 16'hF000, 16'h0000), 1'b0, 4'd7, 4'd0);
    step(bub, 1'b0, 4'd7, 4'd0);
    step(bub, 1'b0, 4'd7, 4'd0);
    check("r7_before_reset", rd_data_a, 16'h1234);
    check("halted_before_reset", halted, 1'b1);
    reset_dut();

    // Randomized traffic
    rx = bub;
    for (int n = 0; n < 3000; n++) begin
      if (m_halted) begin
        repeat (8) step(bub, 1'b1, 4'($urandom), 4'($urandom));
        reset_dut();
      end
      if (!m_stalled) begin
        logic [3:0] op;
        logic [15:0] ins;
        int sel;
        sel = $urandom_range(0, 99);
        if (sel < 3)       op = 4'($urandom);
        else if (sel < 15) op = 4'h6;
        else if (sel < 25) op = 4'h7;
        else if (sel < 30) op = ($urandom_range(0, 1) != 0) ? 4'hC : 4'hD;
        else               op = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 5));
        ins = 16'($urandom);
        ins[15:12] = op;
        if (op == 4'h7 && $urandom_range(0, 1) != 0) ins[7:4] = 4'h0;
        if ($urandom_range(0, 3) == 0) ins[3:0] = 4'h0;
        rx.v   = ($urandom_range(0, 4) != 0);
        rx.pc  = 16'($urandom) & 16'hFFFE;
        rx.ins = ins;
        rx.res = (op == 4'h6 && $urandom_range(0, 1) != 0) ? rx.pc + 16'd2 : 16'($urandom);
      end
      step(rx, ($urandom_range(0, 9) < 4), 4'($urandom), 4'($urandom));
    end

    repeat (10) step(bub, 1'b1, 4'd0, 4'd0);
    @(negedge clk);
    #1;
    check("print_queue_empty", exp_print.size(), 32'd0);
    check("redirect_queue_empty", exp_redir.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback.md
# writeback

Final pipeline stage, directly downstream of the two-stage ALU. Captures the retiring instruction (`x2_pc`, `x2_ins`, `x2_result`) and owns the 16×16 scalar register file. It provides two bypassed read ports to the fetch/register-read stage. It issues the jump redirect, buffers console output (writes to r0) in a small FIFO, and detects halt.

## Interface

Parameters:
- `PRINT_DEPTH`, default 4: print FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `x2_valid` in 1: `x2_*` holds a real instruction (low for bubbles and flushes).
- `x2_pc` in 16: PC of the retiring instruction.
- `x2_ins` in 16: instruction word.
- `x2_result` in 16: ALU result; for loads, the loaded value; for jumps, the next PC.
- `rd_addr_a`, `rd_addr_b` in 4: read addresses.
- `rd_data_a`, `rd_data_b` out 16: read data, combinational.
- `wb_stall` out 1: hold all upstream stages this cycle.
- `wb_redirect` out 1: flush upstream and refetch.
- `wb_redirect_pc` out 16: refetch target.
- `print_valid` out 1: FIFO head valid.
- `print_data` out 8: FIFO head byte.
- `print_ready` in 1: console accepts the head this cycle.
- `halted` out 1: sticky halt.
- `retired` out 32: retired-instruction counter.

## Operation

- **WB register.** Holds `wb_valid/pc/ins/result`. On each posedge it loads `x2_*` unless `wb_stall`. In the next clause, `wb_rt = wb_ins[3:0]`.
- **Decode from `wb_ins[15:12]`:**
  - `0000/0001/0010/0011/0100/0101/1110`: write `wb_result` to `wb_rt`.
  - `0111` with `ins[7:4]=0` (ld): write `wb_rt`.
  - `0111` store, `1100`, `1101`: no scalar write.
  - `0110`: jump.
  - `1111`: halt.
  - `1000`–`1011` (unused): treated as halt.
- **Write to r0** is a print, not a register write: push `wb_result[7:0]`. r0 always reads 0.
- **Jump.** If `wb_result != wb_pc+2`, assert `wb_redirect` with `wb_redirect_pc = wb_result`. Otherwise no redirect.
- **Read ports.** If the address is nonzero, equals `wb_rt`, and the WB instruction writes registers this cycle, return `wb_result` (bypass). Otherwise return the register file contents.
- **Active.** An instruction is active if `wb_valid && !halted && !wb_stall`. Only an active instruction:
  - commits its write or push,
  - asserts redirect,
  - increments `retired`.
- **Halt.** An active halt sets `halted` at the next edge and counts as retired. While halted:
  - no writes, redirects, pushes or retires;
  - `wb_stall` stays low;
  - the FIFO keeps draining.
- **Print FIFO.** Pointer-based, with `log2(PRINT_DEPTH)+1`-bit count.
  - Push on an active print; pop on `print_valid && print_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo `PRINT_DEPTH`.
- **`wb_stall`** = `wb_valid && !halted && is_print && fifo_full`. It does not depend on `print_ready`: a pop while full frees a slot for the next cycle.

## Timing

- **Reset values:**
  - all registers r1–r15 = 0; `wb_valid` = 0;
  - FIFO empty, so `print_valid`=0 and `print_data`=0;
  - `halted`=0, `retired`=0;
  - `wb_stall`=0, `wb_redirect`=0, `wb_redirect_pc`=0.
- **Reset mid-operation** discards FIFO contents and the pending WB instruction immediately (asynchronous).
- **Latency:** `x2_*` sampled at edge N → register write/push/count visible after edge N+1. Through the bypass, the value is readable during cycle N..N+1.
- **`wb_redirect`** is combinational from the WB register and lasts one cycle per active jump. Upstream squashes on it; redirect takes priority over any upstream state.
- **`wb_stall`** is combinational. While it is high, the WB register and all upstream stages hold. `x2_*` must stay stable.

## Structure

- Shared package `cpu_pkg`: opcode constants (`OP_ADD`…`OP_HALT`), subcode constants (`SUB_LD`, `SUB_ST`), and an `is_reg_writer(opcode, subcode)` function, all reused by the ALU and decode.
- One sub-module: `print_fifo` (parameter `DEPTH`; ports `push`, `din[7:0]`, `full`, `pop`, `dout`, `empty`; same `clk`/`rst`). Register file and decode stay inline.

## Test plan

- **Write + bypass.** `x2` = add (`0x0123`, rt=3) with result `0x00AA`, `rd_addr_a=3`.
  - `rd_data_a=0x00AA` the cycle after capture, via bypass.
  - `rd_data_a=0x00AA` the following cycle, from the register file.
  - `retired=1`.
- **Jumps.**
  - `ins=0x6000`, `pc=0x0010`, result `0x0040` → one-cycle `wb_redirect`, `wb_redirect_pc=0x0040`.
  - Result `0x0012` → no redirect.
- **Print FIFO fill and stall.** Five writes to r0 with bytes `'A'`..`'E'`, `print_ready=0`.
  - Four entries stored; `wb_stall` high on the fifth.
  - Pulse `print_ready` once: pops `'A'`; `'E'` commits the next cycle; order is `B,C,D,E`.
- **Halt.** `ins=0xF000`, then an add to r5.
  - `halted=1`, r5 unchanged, `retired` frozen.
  - Pending FIFO bytes still drain.
- **Register r0.** Any write targeting r0 leaves `rd_data_a(addr 0)=0`. Store and `1100` instructions write no register.
- **Asynchronous reset.** Assert `rst` mid-burst with FIFO at 3 entries and r7=`0x1234`. Immediately (no clock edge):
  - `print_valid=0`, `halted=0`, `retired=0`, r7=0.
